// File: rtl/n64a_vmux.sv
// n64a_vmux: serialises 25-bit pixel words onto the N64 4-phase multiplexed video bus (SYNC, R, G, B).
// A 2-entry FIFO absorbs upstream jitter; a hold register feeds each 4-cycle group; bus outputs are registered.
module n64a_vmux (
  input  logic        VCLK,
  input  logic        nVRST_Tx,
  input  logic        en_i,
  input  logic        vdata_valid_i,
  output logic        vdata_ready_o,
  input  logic [24:0] vdata_i,
  output logic        nVDSYNC_o,
  output logic [6:0]  VD_o,
  output logic        underrun_o,
  input  logic        clr_underrun_i
);

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_R    = 2'd1,
    PH_G    = 2'd2,
    PH_B    = 2'd3
  } phase_e;

  typedef struct packed {
    logic [3:0] sync;
    logic [6:0] r;
    logic [6:0] g;
    logic [6:0] b;
  } pix_t;

  localparam pix_t HOLD_RST = '{sync: 4'hF, r: 7'h00, g: 7'h00, b: 7'h00};

  phase_e     phase_q, phase_d;
  pix_t       hold_q, hold_d;
  logic       underrun_q, underrun_d;
  logic       nvdsync_q, nvdsync_d;
  logic [6:0] vd_q, vd_d;

  pix_t       fifo_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  logic       fifo_full;
  logic       fifo_empty;
  logic       accept;
  logic       load;
  logic       push;
  logic       pop;
  pix_t       head;

  assign fifo_full     = (count_q == 2'd2);
  assign fifo_empty    = (count_q == 2'd0);
  assign head          = fifo_q[rd_ptr_q];
  assign vdata_ready_o = nVRST_Tx & en_i & ~fifo_full;
  assign accept        = vdata_valid_i & vdata_ready_o;
  assign load          = en_i & (phase_q == PH_B);
  // An empty FIFO at the load point hands the incoming word straight to the hold register.
  assign push          = accept & ~(load & fifo_empty);
  assign pop           = load & ~fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge VCLK or negedge nVRST_Tx) begin
    if (!nVRST_Tx) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= vdata_i;
      end
    end
  end

  always_comb begin
    phase_d    = phase_q;
    hold_d     = hold_q;
    underrun_d = underrun_q;
    nvdsync_d  = 1'b1;
    vd_d       = 7'h00;

    if (en_i) begin
      case (phase_q)
        PH_SYNC: begin
          nvdsync_d = 1'b0;
          vd_d      = {3'b000, hold_q.sync};
          phase_d   = PH_R;
        end
        PH_R: begin
          vd_d    = hold_q.r;
          phase_d = PH_G;
        end
        PH_G: begin
          vd_d    = hold_q.g;
          phase_d = PH_B;
        end
        default: begin
          vd_d    = hold_q.b;
          phase_d = PH_SYNC;
        end
      endcase
    end else begin
      phase_d = PH_SYNC;
    end

    // Starved load repeats the last sync pattern over black so timing stays intact.
    if (pop) begin
      hold_d = head;
    end else if (load && accept) begin
      hold_d = vdata_i;
    end else if (load) begin
      hold_d = '{sync: hold_q.sync, r: 7'h00, g: 7'h00, b: 7'h00};
    end

    if (load && fifo_empty && !accept) begin
      underrun_d = 1'b1;
    end else if (clr_underrun_i) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge VCLK or negedge nVRST_Tx) begin
    if (!nVRST_Tx) begin
      phase_q    <= PH_SYNC;
      hold_q     <= HOLD_RST;
      underrun_q <= 1'b0;
      nvdsync_q  <= 1'b1;
      vd_q       <= 7'h00;
    end else begin
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      underrun_q <= underrun_d;
      nvdsync_q  <= nvdsync_d;
      vd_q       <= vd_d;
    end
  end

  assign nVDSYNC_o  = nvdsync_q;
  assign VD_o       = vd_q;
  assign underrun_o = underrun_q;

endmodule
